// File: rtl/tank_motion_ctrl_pkg.sv
// Shared definitions for the tank motion controller: heading codes,
// sequencer states, colours and screen geometry defaults.
package tank_pkg;

    localparam int SCREEN_W_DEF  = 160;
    localparam int SCREEN_H_DEF  = 120;
    localparam int TANK_SIZE_DEF = 9;

    localparam logic [2:0] COLOUR_BG   = 3'b000;
    localparam logic [2:0] COLOUR_TANK = 3'b010;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        START  = 3'd0,
        IDLE   = 3'd1,
        ERASE  = 3'd2,
        UPDATE = 3'd3,
        DRAW   = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Moore outputs carried as one registered bundle
    typedef struct packed {
        logic       ce;
        logic       plot;
        logic [2:0] colour;
        logic       busy;
    } out_t;

endpackage

// File: rtl/tank_motion_ctrl_if.sv
// Bundle of the controller's request, plotter and VGA-side signals.
// master = the motion controller, slave = its environment.
interface tank_motion_ctrl_if;

    logic       move_valid;
    logic [1:0] move_dir;
    logic       finish;
    logic [7:0] xpos;
    logic [6:0] ypos;
    logic [1:0] direction;
    logic       counter_enable;
    logic       plot;
    logic [2:0] colour;
    logic       busy;

    modport master (
        input  move_valid, move_dir, finish,
        output xpos, ypos, direction, counter_enable, plot, colour, busy
    );

    modport slave (
        output move_valid, move_dir, finish,
        input  xpos, ypos, direction, counter_enable, plot, colour, busy
    );

endinterface

// File: rtl/tank_motion_ctrl_frame_tick_gen.sv
// Free-running frame counter 0..DIV-1; tick is high while the count
// sits at DIV-1, i.e. one cycle per frame.
module frame_tick_gen #(
    parameter int DIV = 833333
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count up and wrap at the end of each frame
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_cnt <= '0;
        else if (r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/tank_motion_ctrl.sv
// Tank motion sequencer: owns position and heading, latches move requests
// and frame ticks, and runs erase-update-draw through the sprite plotter.
module tank_motion_ctrl
    import tank_pkg::*;
#(
    parameter int         SCREEN_W    = SCREEN_W_DEF,
    parameter int         SCREEN_H    = SCREEN_H_DEF,
    parameter int         TANK_SIZE   = TANK_SIZE_DEF,
    parameter logic [7:0] X_INIT      = 8'd76,
    parameter logic [6:0] Y_INIT      = 7'd56,
    parameter int         FRAME_DIV   = 833333,
    parameter logic [2:0] TANK_COLOUR = COLOUR_TANK
) (
    input  logic               clk,
    input  logic               resetn,
    tank_motion_ctrl_if.master bus
);

    localparam logic [7:0] X_MAX = 8'(SCREEN_W - TANK_SIZE);
    localparam logic [6:0] Y_MAX = 7'(SCREEN_H - TANK_SIZE);

    logic       w_tick;
    logic       w_tick_eff;
    logic [7:0] w_x_next;
    logic [6:0] w_y_next;

    state_t     r_state;
    out_t       r_out;
    logic [7:0] r_xpos;
    logic [6:0] r_ypos;
    dir_t       r_dir;
    logic       r_req_pend;
    dir_t       r_req_dir;
    logic       r_tick_pend;

    frame_tick_gen #(
        .DIV (FRAME_DIV)
    ) u_frame_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick   (w_tick)
    );

    // Output decode for a given state; registered together with the state
    function automatic out_t decode(input state_t s);
        out_t o;
        o.ce     = 1'b0;
        o.plot   = 1'b0;
        o.colour = COLOUR_BG;
        o.busy   = 1'b1;
        case (s)
            IDLE:  o.busy = 1'b0;
            ERASE: begin
                o.ce   = 1'b1;
                o.plot = 1'b1;
            end
            DRAW: begin
                o.ce     = 1'b1;
                o.plot   = 1'b1;
                o.colour = TANK_COLOUR;
            end
            default: ;
        endcase
        return o;
    endfunction

    // One-pixel horizontal step, saturating at the screen edges
    function automatic logic [7:0] step_x(input logic [7:0] x, input dir_t d);
        if (d == DIR_LEFT)
            return (x == 8'd0) ? 8'd0 : x - 8'd1;
        else if (d == DIR_RIGHT)
            return (x >= X_MAX) ? X_MAX : x + 8'd1;
        else
            return x;
    endfunction

    // One-pixel vertical step, saturating at the screen edges
    function automatic logic [6:0] step_y(input logic [6:0] y, input dir_t d);
        if (d == DIR_UP)
            return (y == 7'd0) ? 7'd0 : y - 7'd1;
        else if (d == DIR_DOWN)
            return (y >= Y_MAX) ? Y_MAX : y + 7'd1;
        else
            return y;
    endfunction

    assign w_tick_eff = w_tick | r_tick_pend;
    assign w_x_next   = step_x(r_xpos, r_req_dir);
    assign w_y_next   = step_y(r_ypos, r_req_dir);

    // Sequencer FSM with registered Moore outputs and the position datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= START;
            r_out   <= decode(START);
            r_xpos  <= X_INIT;
            r_ypos  <= Y_INIT;
            r_dir   <= DIR_UP;
        end else begin
            case (r_state)
                START: begin
                    r_state <= DRAW;
                    r_out   <= decode(DRAW);
                end
                IDLE: begin
                    if (w_tick_eff && r_req_pend) begin
                        r_state <= ERASE;
                        r_out   <= decode(ERASE);
                    end
                end
                ERASE: begin
                    if (bus.finish) begin
                        r_state <= UPDATE;
                        r_out   <= decode(UPDATE);
                    end
                end
                UPDATE: begin
                    // heading always follows the request so a blocked tank still turns
                    r_xpos  <= w_x_next;
                    r_ypos  <= w_y_next;
                    r_dir   <= r_req_dir;
                    r_state <= DRAW;
                    r_out   <= decode(DRAW);
                end
                DRAW: begin
                    if (bus.finish) begin
                        r_state <= DONE;
                        r_out   <= decode(DONE);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_out   <= decode(IDLE);
                end
                default: begin
                    r_state <= IDLE;
                    r_out   <= decode(IDLE);
                end
            endcase
        end
    end

    // Request latch: newest request wins, and one arriving during UPDATE survives the clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_req_pend <= 1'b0;
            r_req_dir  <= DIR_UP;
        end else if (bus.move_valid) begin
            r_req_pend <= 1'b1;
            r_req_dir  <= dir_t'(bus.move_dir);
        end else if (r_state == UPDATE) begin
            r_req_pend <= 1'b0;
        end
    end

    // Tick latch: one-deep memory of a tick that lands mid-sequence, consumed in IDLE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_tick_pend <= 1'b0;
        else if (r_state == IDLE)
            r_tick_pend <= 1'b0;
        else if (w_tick)
            r_tick_pend <= 1'b1;
    end

    assign bus.xpos           = r_xpos;
    assign bus.ypos           = r_ypos;
    assign bus.direction      = r_dir;
    assign bus.counter_enable = r_out.ce;
    assign bus.plot           = r_out.plot;
    assign bus.colour         = r_out.colour;
    assign bus.busy           = r_out.busy;

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Bench for tank_motion_ctrl: a 60-pixel plotter model closes the finish
// loop, stimulus is randomized, and every output is compared each cycle
// against a sequence-timeline reference model.
module tb_tank_motion_ctrl;

    localparam int DIV = 200;

    logic clk;
    logic resetn;
    logic [5:0] pcnt;

    tank_motion_ctrl_if bus ();

    tank_motion_ctrl #(
        .FRAME_DIV (DIV)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plotter model: 60-pixel counter, finish flags pixel 59
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            pcnt <= 6'd0;
        else if (bus.counter_enable)
            pcnt <= (pcnt == 6'd59) ? 6'd0 : pcnt + 6'd1;
        else
            pcnt <= 6'd0;
    end
    assign bus.finish = bus.counter_enable && (pcnt == 6'd59);

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: kind 0 = power-on paint, kind 1 = move sequence begun at m_t0
    int m_kind, m_t0, m_n;
    int mx, my, mdir, mreqdir;
    bit mreq, mtickp;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_init();
        m_kind = 0; m_t0 = 0; m_n = 0;
        mx = 76; my = 56; mdir = 0;
        mreq = 0; mreqdir = 0; mtickp = 0;
    endtask

    function automatic bit model_busy();
        int k;
        k = m_n - m_t0;
        if (m_kind == 0) return (k < 62);
        return (k >= 1) && (k < 123);
    endfunction

    task automatic model_step(input bit mv, input int md);
        int  k;
        bit  tick;
        bit  upd;
        k    = m_n - m_t0;
        tick = ((m_n % DIV) == DIV - 1);
        upd  = (m_kind == 1) && (k == 61);
        if (!model_busy()) begin
            if ((tick || mtickp) && mreq) begin
                m_kind = 1;
                m_t0   = m_n;
            end
            mtickp = 0;
        end else if (tick) begin
            mtickp = 1;
        end
        if (upd) begin
            case (mreqdir)
                0: my = (my > 0)   ? my - 1 : 0;
                1: my = (my < 111) ? my + 1 : 111;
                2: mx = (mx > 0)   ? mx - 1 : 0;
                default: mx = (mx < 151) ? mx + 1 : 151;
            endcase
            mdir = mreqdir;
            if (!mv) mreq = 0;
        end
        if (mv) begin
            mreq    = 1;
            mreqdir = md;
        end
        m_n++;
    endtask

    task automatic check_outputs();
        int k;
        bit e_busy, e_ce;
        int e_col;
        k = m_n - m_t0;
        e_busy = model_busy();
        if (m_kind == 0) begin
            e_ce  = (k >= 1) && (k <= 60);
            e_col = e_ce ? 2 : 0;
        end else begin
            e_ce  = ((k >= 1) && (k <= 60)) || ((k >= 62) && (k <= 121));
            e_col = ((k >= 62) && (k <= 121)) ? 2 : 0;
        end
        check_val("busy",      32'(bus.busy),           32'(e_busy));
        check_val("cnt_en",    32'(bus.counter_enable), 32'(e_ce));
        check_val("plot",      32'(bus.plot),           32'(e_ce));
        check_val("colour",    32'(bus.colour),         32'(e_col));
        check_val("xpos",      32'(bus.xpos),           32'(mx));
        check_val("ypos",      32'(bus.ypos),           32'(my));
        check_val("direction", 32'(bus.direction),      32'(mdir));
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_busy"},   32'(bus.busy),           32'd1);
        check_val({tag, "_cnt_en"}, 32'(bus.counter_enable), 32'd0);
        check_val({tag, "_plot"},   32'(bus.plot),           32'd0);
        check_val({tag, "_colour"}, 32'(bus.colour),         32'd0);
        check_val({tag, "_xpos"},   32'(bus.xpos),           32'd76);
        check_val({tag, "_ypos"},   32'(bus.ypos),           32'd56);
        check_val({tag, "_dir"},    32'(bus.direction),      32'd0);
    endtask

    task automatic do_release();
        @(negedge clk);
        check_reset_vals("rst_hold");
        resetn         = 1'b1;
        bus.move_valid = 1'b0;
        bus.move_dir   = 2'd0;
        model_init();
        model_step(0, 0);
    endtask

    task automatic run_cycle(input bit mv, input int md);
        @(negedge clk);
        cyc++;
        check_outputs();
        bus.move_valid = mv;
        bus.move_dir   = 2'(md);
        model_step(mv, md);
    endtask

    task automatic run_random(input int ncyc, input int rate);
        bit mv;
        for (int i = 0; i < ncyc; i++) begin
            if ((m_kind == 1) && (m_n - m_t0 == 61))
                mv = bit'($urandom_range(0, 1));
            else
                mv = ($urandom_range(0, rate - 1) == 0);
            run_cycle(mv, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        int  x_before, y_before;
        bit  found;
        resetn         = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_dir   = 2'd0;
        repeat (3) @(negedge clk);
        do_release();

        // Hold a right request until the tank saturates at the right edge
        for (int i = 0; i < 17000; i++) run_cycle(1, 3);
        check_val("x_right_clamp", 32'(bus.xpos), 32'd151);
        check_val("dir_right",     32'(bus.direction), 32'd3);

        // Hold an up request until it saturates at the top edge
        for (int i = 0; i < 13000; i++) run_cycle(1, 0);
        check_val("y_top_clamp", 32'(bus.ypos), 32'd0);
        check_val("x_held",      32'(bus.xpos), 32'd151);

        // Drain any pending request, then three pulses before a single tick
        for (int i = 0; i < 400; i++) run_cycle(0, 0);
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (!model_busy() && !mreq && ((m_n % DIV) < 40)) found = 1;
            else run_cycle(0, 0);
        end
        check_val("pulse_window", 32'(found), 32'd1);
        x_before = mx;
        y_before = my;
        run_cycle(1, 0);
        run_cycle(0, 0);
        run_cycle(1, 1);
        run_cycle(0, 0);
        run_cycle(1, 2);
        for (int i = 0; i < 400; i++) run_cycle(0, 0);
        check_val("pulses_x", 32'(bus.xpos), 32'(x_before - 1));
        check_val("pulses_y", 32'(bus.ypos), 32'(y_before));
        check_val("pulses_dir", 32'(bus.direction), 32'd2);

        // Random traffic, including requests landing in UPDATE
        run_random(12000, 40);

        // Asynchronous reset at erase pixel 30
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if ((m_kind == 1) && (m_n - m_t0 == 30)) found = 1;
            else run_random(1, 8);
        end
        check_val("erase30_reached", 32'(found), 32'd1);
        if (found) begin
            run_cycle(0, 0);
            #1 resetn = 1'b0;
            #1 check_reset_vals("async_rst");
            repeat (2) @(negedge clk);
            do_release();
            run_random(1500, 10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
